uart_rx: RTL

Serial receiver downstream of the UART transmitter: recovers 8N1 frames (start 0, 8 data bits LSB-first, stop 1) from the `rx` line using an oversampling tick. Received bytes are held in a one-entry output buffer with a read handshake, and framing and overrun errors are flagged. It sits between the board/loopback serial line and the byte-consumer logic, and mirrors the transmitter's frame format exactly.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync2.sv | 21 ++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default frame geometry, frame-bit levels.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // 2-of-3 vote used for noise-tolerant bit sampling
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; RST_VAL sets both flops on reset.
`timescale 1ns/1ps
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {2{RST_VAL}};
    else     sync_q <= {sync_q[0], d};
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampling tick, one-entry read buffer, framing/overrun flags.
// Define UART_RX_MAJORITY_EN to take every bit sample as a 2-of-3 vote over three ticks.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_rd,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam int unsigned H  = OVERSAMPLE / 2 - 1;
  localparam int unsigned F  = OVERSAMPLE - 1;

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 rx_s;
  logic                 sample_c;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;

  // rx_s from the two previous ticks; every tick updates it, so at sample point P it holds P-1, P-2
  always_comb begin
    hist_d = hist_q;
    if (rx_en) hist_d = {hist_q[0], rx_s};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= hist_d;
  end

  assign sample_c = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign sample_c = rx_s;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q & ~data_rd;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_en && rx_s == START_BIT) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (rx_en) begin
          if (cnt_q == CW'(H)) begin
            if (sample_c == START_BIT) begin
              cnt_d     = '0;
              bit_cnt_d = '0;
              state_d   = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (rx_en) begin
          if (cnt_q == CW'(F)) begin
            shift_d   = {sample_c, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BW'(1);
            cnt_d     = '0;
            if (bit_cnt_q == BW'(DATA_BITS - 1)) state_d = STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      STOP: begin
        if (rx_en) begin
          if (cnt_q == CW'(F)) begin
            state_d = IDLE;
            cnt_d   = '0;
            // A read in the same cycle frees the buffer, so the new byte wins
            if (sample_c != STOP_BIT) begin
              frame_err_d = 1'b1;
            end else if (!data_valid_q || data_rd) begin
              data_out_d   = shift_q;
              data_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
